bit_serial_subtractor: RTL
==========================

Name: bit_serial_subtractor

Overview:
- Sequential counterpart to the team's combinational full adder: computes A − B one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Sits behind the board wrapper. Switches supply operands, a key press supplies `start`, and LEDs show `diff`, `borrow`, `busy` and `done`.
- Single-shot request/complete handshake. Result is held until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32

Ports:
- clk  input  1  system clock, rising edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the edge that accepts start
- b  input  WIDTH  subtrahend; captured on the edge that accepts start
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  (a − b) mod 2^WIDTH; registered, stable between completions
- borrow  output  1  final borrow; 1 iff a < b unsigned
- ovf  output  1  signed overflow; present only with OVF_DETECT_EN

Behaviour:
- Reset (rst_n=0, async, takes effect immediately):
  - state=IDLE.
  - busy=0, done=0, diff=0, borrow=0, ovf=0.
  - Operand shift regs, bit counter and borrow flop all cleared.
- States and transitions:
  - IDLE → RUN on a rising edge with start=1.
  - RUN → DONE on the edge that processes bit WIDTH−1.
  - DONE → IDLE unconditionally on the next edge.
- Start acceptance (edge k, start=1 in IDLE):
  - sa←a, sb←b, br←0, cnt←0.
  - start in RUN or DONE is ignored, not queued.
  - a and b may change freely after edge k.
- Each RUN edge:
  - d = sa[0]^sb[0]^br.
  - br ← (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - Result shift reg ← {d, res[WIDTH−1:1]}.
  - sa, sb shift right 1; cnt ← cnt+1.
- Completion (edge k+WIDTH, the last RUN edge):
  - diff ← completed result; borrow ← final br.
  - state=DONE; done=1 for exactly one cycle (edges k+WIDTH to k+WIDTH+1).
- Timing:
  - busy=1 from edge k to edge k+WIDTH; busy and done are never both 1.
  - Latency from accepting edge to done high = WIDTH cycles.
  - Minimum start-to-start spacing = WIDTH+2 cycles; start held high continuously yields one operation every WIDTH+2 cycles.
- Output stability:
  - diff and borrow change only at completion edges or on reset.
  - The intermediate shift state is never visible on the outputs.
- Boundary conditions:
  - a=b: diff=0, borrow=0.
  - a=0, b=2^WIDTH−1: diff=1, borrow=1.
  - Counter width is clog2(WIDTH)+1; no wrap inside an operation.
- Reset mid-RUN: operation aborted; all outputs at reset values; no done pulse.

Optional Feature:
- Macro OVF_DETECT_EN.
- Defined:
  - Port ovf exists; registered at completion together with diff.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
  - Held until the next completion; cleared by reset.
- Undefined: port ovf absent; no sign flops synthesized; all other behaviour identical.

Test Plan:
- WIDTH=8, a=100, b=37, 1-cycle start → busy for 8 cycles, done pulse 8 cycles after accept, diff=63, borrow=0, ovf=0.
- a=5, b=10 → diff=251 (0xFB), borrow=1; a and b changed to 0xAA/0x55 during RUN → result unaffected.
- a=0x80, b=0x01 → diff=0x7F, borrow=0, ovf=1; a=0x7F, b=0xFF → diff=0x80, borrow=1, ovf=1 (OVF_DETECT_EN build).
- start held high 40 cycles with a=b=0x3C → exactly 4 done pulses spaced 10 cycles, each diff=0, borrow=0; mid-RUN start pulses produce no extra operation.
- Complete a=9, b=3 (diff=6); start a=1, b=2, assert rst_n=0 at RUN cycle 4 → outputs immediately 0, no done; after release a=200, b=199 → diff=1, borrow=0.

Source files
------------

// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first serial A-B through one full-subtractor cell
// Optional signed-overflow output when OVF_DETECT_EN is defined.
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef OVF_DETECT_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bit_d;
    logic             br_next;

`ifdef OVF_DETECT_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    // The full-subtractor cell
    always_comb begin
        bit_d   = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef OVF_DETECT_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
`ifdef OVF_DETECT_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                br_d  = br_next;
                res_d = {bit_d, res_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                // Outputs only move here, so partial results never show
                if (cnt_q == LAST_BIT) begin
                    state_d  = S_DONE;
                    diff_d   = res_d;
                    borrow_d = br_next;
`ifdef OVF_DETECT_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef OVF_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
